dm_sba_axi_bridge: RTL and testbench
====================================

Name: dm_sba_axi_bridge

Overview:
- Converts the debug module's system-bus master port (req/gnt/r_valid memory protocol) into single-beat AXI4 read and write transactions.
- Sits directly downstream of the debug module's master interface and upstream of the narrow-to-wide AXI data-width converter.
- Handles exactly one outstanding transaction.
- Always returns an r_valid pulse, for writes and reads alike, because the system-bus access engine waits on r_valid for both.

Parameters:
ADDR_WIDTH, 32, AXI and request address width
DATA_WIDTH, 64, request/AXI data width (power of two, >= 32)
ID_WIDTH, 4, AXI ID width
USER_WIDTH, 1, AXI user width
AXI_ID, 0, constant ID driven on aw_id/ar_id

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_i  in  1  request valid from debug module
we_i  in  1  1=write, 0=read
addr_i  in  ADDR_WIDTH  byte address
wdata_i  in  DATA_WIDTH  write data
be_i  in  DATA_WIDTH/8  byte enables
gnt_o  out  1  request accepted
r_valid_o  out  1  one-cycle completion pulse
r_rdata_o  out  DATA_WIDTH  read data (0 for writes)
r_err_o  out  1  completion carried SLVERR/DECERR
aw_valid_o/aw_ready_i, aw_addr_o[ADDR_WIDTH], aw_id_o[ID_WIDTH], aw_len_o[8], aw_size_o[3], aw_burst_o[2], aw_user_o[USER_WIDTH]  AXI AW
w_valid_o/w_ready_i, w_data_o[DATA_WIDTH], w_strb_o[DATA_WIDTH/8], w_last_o, w_user_o  AXI W
b_valid_i/b_ready_o, b_resp_i[2], b_id_i  AXI B
ar_valid_o/ar_ready_i, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o, ar_user_o  AXI AR
r_valid_i/r_ready_o, r_data_i[DATA_WIDTH], r_resp_i[2], r_last_i, r_id_i  AXI R

Behaviour:
- Single clock domain; clk is the only clock.
- rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- States: IDLE, WRITE, WRITE_RESP, READ_ADDR, READ_DATA, DONE.
- Reset values:
  - state=IDLE.
  - All *_valid_o=0; b_ready_o=0; r_ready_o=0.
  - r_valid_o=0, r_err_o=0, r_rdata_o=0.
  - Address, data and strobe registers=0.
- gnt_o = req_i & (state==IDLE), combinational. All other outputs are registered.
- IDLE with req_i:
  - Capture addr, wdata, be, we.
  - Next state is WRITE if we_i, else READ_ADDR.
- Address and control fields:
  - aw_addr/ar_addr = captured addr with the low log2(DATA_WIDTH/8) bits cleared.
  - size = log2(DATA_WIDTH/8); len=0; burst=INCR(01); user=0; id=AXI_ID.
- WRITE:
  - aw_valid_o and w_valid_o are asserted together on the cycle after the grant.
  - w_last_o=1; w_strb_o=captured be.
  - Each channel deasserts independently on its own handshake; aw_done and w_done flags are tracked.
  - Move to WRITE_RESP in the cycle both handshakes are complete, including when both complete in the same cycle.
  - W may complete before AW; both orders must work.
- WRITE_RESP:
  - b_ready_o=1.
  - On b_valid_i: latch r_err = b_resp_i[1] and r_rdata=0, then go to DONE.
- READ_ADDR: ar_valid_o=1 until ar_ready_i, then go to READ_DATA.
- READ_DATA:
  - r_ready_o=1.
  - On r_valid_i: latch r_data_i and r_err = r_resp_i[1], then go to DONE.
  - r_last_i is ignored, since len is always 0.
- DONE:
  - r_valid_o=1 for exactly one cycle; r_rdata_o and r_err_o are stable in that cycle.
  - Next state is IDLE.
  - r_rdata_o and r_err_o hold their values until the next completion.
- gnt_o is 0 in every state except IDLE, so a back-to-back request is granted no earlier than the cycle after the r_valid pulse.
- Minimum latencies, with grant at t0:
  - Write: AW/W valid at t1, B earliest at t2, r_valid at t3.
  - Read: AR valid at t1, R earliest at t2, r_valid at t3.
- b_ready_o and r_ready_o are 0 outside their wait states, so stray B/R beats are never accepted. IDs are not checked.
- Valid signals are never withdrawn before their handshake, except by reset.
- Reset mid-transaction:
  - All valid/ready outputs drop on the next edge; state returns to IDLE; no r_valid pulse is issued.
  - The interconnect shares this reset, so no AXI-protocol cleanup is performed.

Test Plan:
- Write 0x1122334455667788 to 0x8000_0004 with be=0xF0 and immediate aw/w ready, B=OKAY at t2 -> aw_addr=0x8000_0000, w_strb=0xF0, size=3, len=0; r_valid pulses at t3 with r_err=0 and rdata=0.
- Write with w_ready asserted 3 cycles before aw_ready, then the reverse order -> each valid drops at its own handshake; b_ready rises only after both handshakes; exactly one r_valid.
- Read from 0x1000_0008 with ar_ready delayed 2 cycles, R returns 0xDEADBEEFCAFEF00D with resp=OKAY -> r_rdata_o=0xDEADBEEFCAFEF00D, r_err_o=0, r_valid high for exactly 1 cycle.
- Read with R resp=DECERR (11), then write with B resp=SLVERR (10) -> r_err_o=1 on both completions.
- req_i held high continuously for 3 reads -> gnt_o high only in IDLE cycles, 3 grants, 3 r_valid pulses, never two transactions outstanding.
- rst asserted in WRITE_RESP with b_valid_i low -> next cycle all valid/ready outputs are 0, state=IDLE, no r_valid; a new request is granted immediately after rst deasserts.

Source files
------------

// File: rtl/dm_sba_axi_bridge.sv
// Bridges the debug module's req/gnt/r_valid system-bus port to single-beat AXI4.
// One transaction in flight; every access, read or write, ends with an r_valid pulse.
module dm_sba_axi_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1,
  parameter int AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic                    gnt_o,
  output logic                    r_valid_o,
  output logic [DATA_WIDTH-1:0]   r_rdata_o,
  output logic                    r_err_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [ID_WIDTH-1:0]     aw_id_o,
  output logic [7:0]              aw_len_o,
  output logic [2:0]              aw_size_o,
  output logic [1:0]              aw_burst_o,
  output logic [USER_WIDTH-1:0]   aw_user_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  output logic                    w_last_o,
  output logic [USER_WIDTH-1:0]   w_user_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic [1:0]              b_resp_i,
  input  logic [ID_WIDTH-1:0]     b_id_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [ID_WIDTH-1:0]     ar_id_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [1:0]              ar_burst_o,
  output logic [USER_WIDTH-1:0]   ar_user_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]              r_resp_i,
  input  logic                    r_last_i,
  input  logic [ID_WIDTH-1:0]     r_id_i
);

  localparam int                    SIZE      = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  typedef enum logic [2:0] {
    IDLE, WRITE, WRITE_RESP, READ_ADDR, READ_DATA, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] be_q, be_d;
  logic                    aw_valid_q, aw_valid_d;
  logic                    w_valid_q, w_valid_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    b_ready_q, b_ready_d;
  logic                    ar_valid_q, ar_valid_d;
  logic                    r_ready_q, r_ready_d;
  logic                    r_valid_q, r_valid_d;
  logic                    r_err_q, r_err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    aw_hs, w_hs;

  // IDs, r_last and the low response bit carry no information for this bridge.
  logic unused_inputs;
  assign unused_inputs = ^{b_resp_i[0], b_id_i, r_resp_i[0], r_last_i, r_id_i};

  assign aw_hs = aw_valid_q & aw_ready_i;
  assign w_hs  = w_valid_q & w_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      r_err_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      r_valid_q  <= r_valid_d;
      r_err_q    <= r_err_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    b_ready_d  = b_ready_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    r_valid_d  = 1'b0;
    r_err_d    = r_err_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d  = addr_i & ~ADDR_MASK;
          wdata_d = wdata_i;
          be_d    = be_i;
          if (we_i) begin
            state_d    = WRITE;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end else begin
            state_d    = READ_ADDR;
            ar_valid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (aw_hs) aw_valid_d = 1'b0;
        if (w_hs)  w_valid_d  = 1'b0;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        // Leave as soon as both channels are through, even if they finish together.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = WRITE_RESP;
          b_ready_d = 1'b1;
        end
      end
      WRITE_RESP: begin
        if (b_valid_i) begin
          state_d   = DONE;
          b_ready_d = 1'b0;
          r_err_d   = b_resp_i[1];
          rdata_d   = '0;
          r_valid_d = 1'b1;
        end
      end
      READ_ADDR: begin
        if (ar_ready_i) begin
          state_d    = READ_DATA;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      READ_DATA: begin
        if (r_valid_i) begin
          state_d   = DONE;
          r_ready_d = 1'b0;
          rdata_d   = r_data_i;
          r_err_d   = r_resp_i[1];
          r_valid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o      = req_i & (state_q == IDLE);
  assign r_valid_o  = r_valid_q;
  assign r_rdata_o  = rdata_q;
  assign r_err_o    = r_err_q;

  assign aw_valid_o = aw_valid_q;
  assign aw_addr_o  = addr_q;
  assign aw_id_o    = ID_WIDTH'(AXI_ID);
  assign aw_len_o   = 8'd0;
  assign aw_size_o  = 3'(SIZE);
  assign aw_burst_o = 2'b01;
  assign aw_user_o  = '0;

  assign w_valid_o  = w_valid_q;
  assign w_data_o   = wdata_q;
  assign w_strb_o   = be_q;
  assign w_last_o   = 1'b1;
  assign w_user_o   = '0;

  assign b_ready_o  = b_ready_q;

  assign ar_valid_o = ar_valid_q;
  assign ar_addr_o  = addr_q;
  assign ar_id_o    = ID_WIDTH'(AXI_ID);
  assign ar_len_o   = 8'd0;
  assign ar_size_o  = 3'(SIZE);
  assign ar_burst_o = 2'b01;
  assign ar_user_o  = '0;

  assign r_ready_o  = r_ready_q;

endmodule

// File: tb/tb_dm_sba_axi_bridge.sv
// Directed bench for dm_sba_axi_bridge: AXI slave responses are driven step by step,
// completions are checked against a queue of expected results.
module tb_dm_sba_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i;
  logic [31:0] addr_i;
  logic [63:0] wdata_i;
  logic [7:0]  be_i;
  logic        gnt_o, r_valid_o, r_err_o;
  logic [63:0] r_rdata_o;
  logic        aw_valid_o, aw_ready_i;
  logic [31:0] aw_addr_o, ar_addr_o;
  logic [3:0]  aw_id_o, ar_id_o, b_id_i, r_id_i;
  logic [7:0]  aw_len_o, ar_len_o;
  logic [2:0]  aw_size_o, ar_size_o;
  logic [1:0]  aw_burst_o, ar_burst_o;
  logic [0:0]  aw_user_o, w_user_o, ar_user_o;
  logic        w_valid_o, w_ready_i, w_last_o;
  logic [63:0] w_data_o, r_data_i;
  logic [7:0]  w_strb_o;
  logic        b_valid_i, b_ready_o;
  logic [1:0]  b_resp_i, r_resp_i;
  logic        ar_valid_o, ar_ready_i;
  logic        r_valid_i, r_ready_o, r_last_i;

  dm_sba_axi_bridge dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .r_err_o(r_err_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .aw_id_o(aw_id_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
    .aw_burst_o(aw_burst_o), .aw_user_o(aw_user_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
    .w_strb_o(w_strb_o), .w_last_o(w_last_o), .w_user_o(w_user_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i), .b_id_i(b_id_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .ar_id_o(ar_id_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
    .ar_burst_o(ar_burst_o), .ar_user_o(ar_user_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
    .r_resp_i(r_resp_i), .r_last_i(r_last_i), .r_id_i(r_id_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } cpl_t;

  cpl_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_push   = 0;
  int   n_pulses = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: each r_valid pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && r_valid_o) begin
      cpl_t e;
      n_pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("cpl_rdata", r_rdata_o, e.rdata);
        chk("cpl_err", {63'd0, r_err_o}, {63'd0, e.err});
      end
    end
  end

  task automatic push(input logic [63:0] d, input logic e);
    cpl_t c;
    c.rdata = d;
    c.err   = e;
    sb.push_back(c);
    n_push++;
  endtask

  // Caller must be in an IDLE cycle; the grant happens in this cycle.
  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be,
                          input int awd, input int wd, input int bd, input logic [1:0] bresp);
    bit aw_done = 0, w_done = 0;
    int k = 1;
    req_i = 1; we_i = 1; addr_i = a; wdata_i = d; be_i = be;
    #1 chk("wr_gnt", {63'd0, gnt_o}, 64'd1);
    push(64'd0, bresp[1]);
    cyc();
    req_i = 0;
    while (!(aw_done && w_done) && k < 20) begin
      aw_ready_i = (k > awd);
      w_ready_i  = (k > wd);
      #1;
      chk("aw_valid", {63'd0, aw_valid_o}, {63'd0, !aw_done});
      chk("w_valid", {63'd0, w_valid_o}, {63'd0, !w_done});
      chk("b_ready_early", {63'd0, b_ready_o}, 64'd0);
      if (k == 1) begin
        chk("aw_addr", {32'd0, aw_addr_o}, {32'd0, a & 32'hFFFF_FFF8});
        chk("w_strb", {56'd0, w_strb_o}, {56'd0, be});
        chk("w_data", w_data_o, d);
        chk("aw_ctrl", {48'd0, aw_len_o, aw_size_o, aw_burst_o, w_last_o, aw_id_o},
            {48'd0, 8'd0, 3'd3, 2'b01, 1'b1, 4'd0});
      end
      if (aw_ready_i) aw_done = 1;
      if (w_ready_i)  w_done  = 1;
      cyc();
      k++;
    end
    aw_ready_i = 0; w_ready_i = 0;
    for (int j = 0; j < bd; j++) begin
      #1 chk("b_ready_wait", {61'd0, b_ready_o, aw_valid_o, w_valid_o}, 64'd4);
      cyc();
    end
    b_valid_i = 1; b_resp_i = bresp;
    #1 chk("b_ready", {63'd0, b_ready_o}, 64'd1);
    cyc();
    b_valid_i = 0; b_resp_i = 2'b00;
    #1 chk("wr_rvalid", {63'd0, r_valid_o}, 64'd1);
    cyc();
    #1 chk("wr_rvalid_end", {62'd0, r_valid_o, b_ready_o}, 64'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input int ard, input int rd,
                         input logic [63:0] d, input logic [1:0] rresp);
    req_i = 1; we_i = 0; addr_i = a;
    #1 chk("rd_gnt", {63'd0, gnt_o}, 64'd1);
    push(d, rresp[1]);
    cyc();
    req_i = 0;
    for (int k = 1; k <= ard + 1; k++) begin
      ar_ready_i = (k > ard);
      #1;
      chk("ar_valid", {62'd0, ar_valid_o, r_ready_o}, 64'd2);
      if (k == 1) chk("ar_addr", {32'd0, ar_addr_o}, {32'd0, a & 32'hFFFF_FFF8});
      cyc();
    end
    ar_ready_i = 0;
    for (int j = 0; j < rd; j++) begin
      #1 chk("r_ready_wait", {62'd0, r_ready_o, ar_valid_o}, 64'd2);
      cyc();
    end
    r_valid_i = 1; r_data_i = d; r_resp_i = rresp; r_last_i = 1;
    #1 chk("r_ready", {63'd0, r_ready_o}, 64'd1);
    cyc();
    r_valid_i = 0; r_data_i = 64'd0; r_resp_i = 2'b00; r_last_i = 0;
    #1;
    chk("rd_rvalid", {63'd0, r_valid_o}, 64'd1);
    chk("rd_rdata", r_rdata_o, d);
    cyc();
    #1 chk("rd_rvalid_end", {62'd0, r_valid_o, r_ready_o}, 64'd0);
  endtask

  initial begin
    rst = 1; req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; be_i = '0;
    aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_resp_i = 0; b_id_i = 4'd5;
    ar_ready_i = 0; r_valid_i = 0; r_data_i = '0; r_resp_i = 0; r_last_i = 0; r_id_i = 4'd7;
    cyc(); cyc();
    chk("rst_valids", {58'd0, aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o, r_valid_o}, 64'd0);
    chk("rst_rdata", r_rdata_o, 64'd0);
    chk("rst_err", {63'd0, r_err_o}, 64'd0);
    chk("rst_addr", {32'd0, aw_addr_o}, 64'd0);
    rst = 0;
    cyc();

    do_write(32'h8000_0004, 64'h1122_3344_5566_7788, 8'hF0, 0, 0, 0, 2'b00);
    do_write(32'h8000_0010, 64'hAAAA_0000_BBBB_1111, 8'h0F, 3, 0, 1, 2'b00);
    do_write(32'h8000_0018, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 3, 0, 2'b00);
    do_read(32'h1000_0008, 2, 0, 64'hDEAD_BEEF_CAFE_F00D, 2'b00);
    chk("rd_err_okay", {63'd0, r_err_o}, 64'd0);
    do_read(32'h2000_0003, 0, 2, 64'h5555_6666_7777_8888, 2'b11);
    chk("rd_err_decerr", {63'd0, r_err_o}, 64'd1);
    do_write(32'h3000_0000, 64'h0, 8'h01, 1, 1, 0, 2'b10);
    chk("wr_err_slverr", {63'd0, r_err_o}, 64'd1);
    chk("wr_rdata_zero", r_rdata_o, 64'd0);

    // req held high with immediate slave: one grant every 4 cycles.
    req_i = 1; we_i = 0; addr_i = 32'h4000_0000; ar_ready_i = 1; r_valid_i = 1; r_resp_i = 2'b00;
    for (int i = 0; i < 12; i++) begin
      r_data_i = 64'h0000_00A0 + 64'(i);
      #1 chk("held_gnt", {63'd0, gnt_o}, {63'd0, (i % 4) == 0});
      if ((i % 4) == 0) push(64'h0000_00A0 + 64'(i + 2), 1'b0);
      cyc();
    end
    req_i = 0; ar_ready_i = 0; r_valid_i = 0; r_data_i = '0;
    #1 chk("held_idle", {63'd0, gnt_o}, 64'd0);
    cyc();

    // Reset while waiting for B: abandon the write, no completion.
    req_i = 1; we_i = 1; addr_i = 32'h5000_0000; wdata_i = 64'h77; be_i = 8'hFF;
    aw_ready_i = 1; w_ready_i = 1;
    cyc();
    req_i = 0;
    cyc();
    aw_ready_i = 0; w_ready_i = 0;
    #1 chk("rst_mid_bready", {63'd0, b_ready_o}, 64'd1);
    rst = 1;
    cyc();
    rst = 0;
    #1 chk("rst_mid_outs", {58'd0, aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o, r_valid_o}, 64'd0);
    do_read(32'h6000_0010, 0, 0, 64'hFEED_FACE_0BAD_BEEF, 2'b00);
    cyc(); cyc();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("pulse_count", 64'(n_pulses), 64'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
